fix_seq_manager: RTL and testbench
==================================

# fix_seq_manager

Multi-host FIX sequence-number manager; successor to the fixed-host sequence generator in `fix_engine`. Per host it keeps one outgoing MsgSeqNum(34) counter and one expected-incoming counter. On request it issues the next outgoing number as binary plus left-zero-stripped ASCII for the message builder. It checks incoming numbers against the expected value and flags gaps (resend range) and low numbers.

## Interface
Parameters:
- `HOST_ADDR_WIDTH`, 2: host index width; hosts = 2**HOST_ADDR_WIDTH.
- `SEQ_WIDTH`, 20: binary sequence-number width.
- `DIGITS`, 7: ASCII digit capacity. Must satisfy 10**DIGITS > 2**SEQ_WIDTH-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `out_req_i` in 1: request next outgoing number.
- `out_host_i` in HOST_ADDR_WIDTH: host for the request.
- `out_ready_o` out 1: request can be accepted this cycle.
- `out_valid_o` out 1: one-cycle pulse; result fields valid.
- `out_seq_o` out SEQ_WIDTH: issued number, binary.
- `out_ascii_o` out 8*DIGITS: ASCII digits. Least significant digit in [7:0]. Bytes above the most significant digit are 8'h00.
- `out_len_o` out 4: significant digit count, 1..DIGITS.
- `seq_wrap_o` out 1: one-cycle pulse; an outgoing counter wrapped.
- `in_valid_i` in 1: incoming number to check.
- `in_host_i` in HOST_ADDR_WIDTH: source host.
- `in_seq_i` in SEQ_WIDTH: received MsgSeqNum.
- `in_ok_o`, `in_gap_o`, `in_low_o` out 1 each: mutually exclusive one-cycle result pulses.
- `gap_begin_o`, `gap_end_o` out SEQ_WIDTH: resend range, valid with `in_gap_o`.
- `seq_reset_i` in 1: SequenceReset / logon reset for one host.
- `seq_reset_host_i` in HOST_ADDR_WIDTH, `seq_reset_val_i` in SEQ_WIDTH: target host and new value.

## Operation
- **Reset:** all outgoing and expected counters are set to 1. Every output is 0 except `out_ready_o`, which is 1.
- **Outgoing FSM states:** IDLE → CONV → FMT → DONE → IDLE.
  - `out_ready_o` = (state == IDLE or DONE) and !`seq_reset_i`.
  - **Accept** (`out_req_i` && `out_ready_o`): latch counter[`out_host_i`] into the converter, increment that counter, then enter CONV.
  - **Increment at 2**SEQ_WIDTH-1:** the counter wraps to 1 (never 0) and `seq_wrap_o` pulses next cycle.
  - **CONV:** iterative double-dabble, one bit per cycle, SEQ_WIDTH cycles.
  - **FMT:** build ASCII bytes (8'h30 + BCD digit), count significant digits, zero the upper bytes. A value of 0 gives len 1 and "0".
  - **DONE:** `out_valid_o`=1 for one cycle. A new request is accepted in DONE.
  - `out_req_i` while not ready is dropped. There is no queuing.
- **Incoming check:** registered, independent of the outgoing FSM. With E = expected[`in_host_i`]:
  - `in_seq_i` == E: `in_ok_o`, and E increments (wraps to 1 at max).
  - `in_seq_i` > E: `in_gap_o`, `gap_begin_o`=E, `gap_end_o`=`in_seq_i`-1. E is unchanged.
  - `in_seq_i` < E: `in_low_o`. E is unchanged.
- **Sequence reset:** sets both counters of `seq_reset_host_i` to `seq_reset_val_i`. A value of 0 is loaded as 1.
- **Simultaneous events:**
  - `seq_reset_i` blocks outgoing accept in that cycle.
  - When `seq_reset_i` and `in_valid_i` hit the same host, the reset wins: the check is evaluated against the old E, but E takes the reset value.
  - An outgoing accept and an incoming check on the same host touch separate counters, so both proceed.
  - A conversion already in flight is unaffected by any later reset of its host.

## Timing
- Outgoing: accept in cycle T gives `out_valid_o` in cycle T+SEQ_WIDTH+2 (default T+22). The counter updates at the end of T.
- Result fields hold their values until the next DONE.
- Incoming: `in_valid_i` in cycle T gives the result pulse in T+1. `gap_*` hold until the next `in_gap_o`.
- Outgoing throughput: one number per SEQ_WIDTH+2 cycles.
- `rst` asserted mid-conversion aborts it. No `out_valid_o` follows, and all counters return to 1.

## Test plan
- Reset, then `out_req_i` host 0 at T → T+22: `out_seq_o`=1, `out_ascii_o`[7:0]=8'h31, upper bytes 0, `out_len_o`=1. A second request gives 2 / 8'h32.
- Host 2 incoming sequence 1, 5, 3, 1:
  - 1 → `in_ok_o`.
  - 5 → `in_gap_o`, begin 2, end 4.
  - 3 → `in_gap_o`, begin 2, end 2.
  - 1 → `in_low_o`.
- `seq_reset_i` host 1 with value 1000, then `out_req_i` host 1 → `out_seq_o`=1000, low 4 bytes 32'h31303030, `out_len_o`=4. Incoming 1000 on host 1 → `in_ok_o`.
- Reset host 3 to 1048575, then `out_req_i` → "1048575", len 7, `seq_wrap_o` pulse. The next request gives 1. Host 0 counter is unchanged.
- `out_req_i` at T+5 during a conversion is dropped: only one `out_valid_o`. Assert `rst` at T+10 → no `out_valid_o`; the next request gives 1.
- Same cycle: `out_req_i`, `in_valid_i` and `seq_reset_i` all on host 0 (value 50), with `in_seq_i`=1:
  - Outgoing is not accepted (`out_ready_o`=0).
  - `in_ok_o` fires.
  - After that cycle, both host 0 counters are 50.

Source files
------------

// File: rtl/fix_seq_manager.sv
// FIX MsgSeqNum manager: per-host outgoing counters with binary-to-ASCII issue, and per-host expected-incoming checks.
// Latency: outgoing result SEQ_WIDTH+2 cycles after accept; incoming check result 1 cycle after in_valid_i.
// Backpressure: out_ready_o low while a conversion is in flight or during seq_reset_i; requests while not ready are dropped.
module fix_seq_manager #(
  parameter int HOST_ADDR_WIDTH = 2,
  parameter int SEQ_WIDTH       = 20,
  parameter int DIGITS          = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       out_req_i,
  input  logic [HOST_ADDR_WIDTH-1:0] out_host_i,
  output logic                       out_ready_o,
  output logic                       out_valid_o,
  output logic [SEQ_WIDTH-1:0]       out_seq_o,
  output logic [8*DIGITS-1:0]        out_ascii_o,
  output logic [3:0]                 out_len_o,
  output logic                       seq_wrap_o,
  input  logic                       in_valid_i,
  input  logic [HOST_ADDR_WIDTH-1:0] in_host_i,
  input  logic [SEQ_WIDTH-1:0]       in_seq_i,
  output logic                       in_ok_o,
  output logic                       in_gap_o,
  output logic                       in_low_o,
  output logic [SEQ_WIDTH-1:0]       gap_begin_o,
  output logic [SEQ_WIDTH-1:0]       gap_end_o,
  input  logic                       seq_reset_i,
  input  logic [HOST_ADDR_WIDTH-1:0] seq_reset_host_i,
  input  logic [SEQ_WIDTH-1:0]       seq_reset_val_i
);

  localparam int HOSTS = 2**HOST_ADDR_WIDTH;
  localparam int BW    = 4*DIGITS;
  localparam int CW    = $clog2(SEQ_WIDTH+1);
  localparam logic [SEQ_WIDTH-1:0] SEQ_MAX  = '1;
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE  = SEQ_WIDTH'(1);
  localparam logic [CW-1:0]        LAST_BIT = CW'(SEQ_WIDTH-1);

  typedef enum logic [1:0] {IDLE, CONV, FMT, DONE} state_t;

  state_t                state, state_nx;
  logic [SEQ_WIDTH-1:0]  out_cnt [HOSTS];
  logic [SEQ_WIDTH-1:0]  exp_cnt [HOSTS];
  logic [SEQ_WIDTH-1:0]  bin_sh;
  logic [SEQ_WIDTH-1:0]  seq_lat;
  logic [BW-1:0]         bcd;
  logic [BW-1:0]         bcd_adj;
  logic [CW-1:0]         bit_cnt;
  logic                  accept;
  logic [SEQ_WIDTH-1:0]  reset_val;
  logic [SEQ_WIDTH-1:0]  in_exp;
  logic [8*DIGITS-1:0]   ascii_c;
  logic [3:0]            len_c;

  // Counters never hold 0: the successor of the maximum is 1.
  function automatic logic [SEQ_WIDTH-1:0] seq_inc(input logic [SEQ_WIDTH-1:0] v);
    return (v == SEQ_MAX) ? SEQ_ONE : v + SEQ_ONE;
  endfunction

  assign reset_val   = (seq_reset_val_i == '0) ? SEQ_ONE : seq_reset_val_i;
  assign in_exp      = exp_cnt[in_host_i];
  assign out_valid_o = (state == DONE);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, ready and accept decode
  always_comb begin
    state_nx    = state;
    out_ready_o = ((state == IDLE) || (state == DONE)) && !seq_reset_i;
    accept      = out_req_i && out_ready_o;
    case (state)
      IDLE:    if (accept) state_nx = CONV;
      CONV:    if (bit_cnt == LAST_BIT) state_nx = FMT;
      FMT:     state_nx = DONE;
      DONE:    state_nx = accept ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Double-dabble add-3 correction applied before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // ASCII formatting: significant-digit count (min 1) and zero bytes above it
  always_comb begin
    len_c   = 4'd1;
    ascii_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) len_c = 4'(i+1);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (4'(i) < len_c) ascii_c[8*i +: 8] = 8'h30 + {4'd0, bcd[4*i +: 4]};
    end
  end

  // Conversion datapath and result registers that hold until the next DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh      <= '0;
      seq_lat     <= '0;
      bcd         <= '0;
      bit_cnt     <= '0;
      out_seq_o   <= '0;
      out_ascii_o <= '0;
      out_len_o   <= '0;
    end else begin
      if (accept) begin
        bin_sh  <= out_cnt[out_host_i];
        seq_lat <= out_cnt[out_host_i];
        bcd     <= '0;
        bit_cnt <= '0;
      end else if (state == CONV) begin
        bin_sh  <= bin_sh << 1;
        bcd     <= (bcd_adj << 1) | BW'(bin_sh[SEQ_WIDTH-1]);
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (state == FMT) begin
        out_seq_o   <= seq_lat;
        out_ascii_o <= ascii_c;
        out_len_o   <= len_c;
      end
    end
  end

  // Per-host counters; a sequence reset overrides an incoming increment on the same host
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < HOSTS; h++) begin
        out_cnt[h] <= SEQ_ONE;
        exp_cnt[h] <= SEQ_ONE;
      end
      seq_wrap_o <= 1'b0;
    end else begin
      seq_wrap_o <= accept && (out_cnt[out_host_i] == SEQ_MAX);
      if (accept) out_cnt[out_host_i] <= seq_inc(out_cnt[out_host_i]);
      if (in_valid_i && (in_seq_i == in_exp)) exp_cnt[in_host_i] <= seq_inc(in_exp);
      if (seq_reset_i) begin
        out_cnt[seq_reset_host_i] <= reset_val;
        exp_cnt[seq_reset_host_i] <= reset_val;
      end
    end
  end

  // Incoming check against the expected value before any same-cycle update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ok_o     <= 1'b0;
      in_gap_o    <= 1'b0;
      in_low_o    <= 1'b0;
      gap_begin_o <= '0;
      gap_end_o   <= '0;
    end else begin
      in_ok_o  <= in_valid_i && (in_seq_i == in_exp);
      in_gap_o <= in_valid_i && (in_seq_i >  in_exp);
      in_low_o <= in_valid_i && (in_seq_i <  in_exp);
      if (in_valid_i && (in_seq_i > in_exp)) begin
        gap_begin_o <= in_exp;
        gap_end_o   <= in_seq_i - SEQ_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fix_seq_manager.sv
// Bench for fix_seq_manager: directed scenarios then random traffic, checked by a scoreboard.
// Expected results come from a per-host counter model using plain integer arithmetic and decimal strings.
// A monitor on the falling edge pops and compares whenever the DUT pulses a result.
module tb_fix_seq_manager;
  localparam int HAW  = 2;
  localparam int SW   = 20;
  localparam int DG   = 7;
  localparam int NH   = 4;
  localparam int LAT  = SW + 2;
  localparam int MAXV = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_req = 1'b0, out_ready, out_valid, seq_wrap;
  logic [HAW-1:0] out_host = '0, in_host = '0, seq_reset_host = '0;
  logic [SW-1:0] out_seq, in_seq = '0, gap_begin, gap_end, seq_reset_val = '0;
  logic [8*DG-1:0] out_ascii;
  logic [3:0] out_len;
  logic in_valid = 1'b0, in_ok, in_gap, in_low, seq_reset = 1'b0;

  fix_seq_manager #(.HOST_ADDR_WIDTH(HAW), .SEQ_WIDTH(SW), .DIGITS(DG)) dut (
    .clk(clk), .rst(rst),
    .out_req_i(out_req), .out_host_i(out_host), .out_ready_o(out_ready),
    .out_valid_o(out_valid), .out_seq_o(out_seq), .out_ascii_o(out_ascii),
    .out_len_o(out_len), .seq_wrap_o(seq_wrap),
    .in_valid_i(in_valid), .in_host_i(in_host), .in_seq_i(in_seq),
    .in_ok_o(in_ok), .in_gap_o(in_gap), .in_low_o(in_low),
    .gap_begin_o(gap_begin), .gap_end_o(gap_end),
    .seq_reset_i(seq_reset), .seq_reset_host_i(seq_reset_host), .seq_reset_val_i(seq_reset_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int cyc; logic [SW-1:0] seq; logic [8*DG-1:0] asc; logic [3:0] len; } out_exp_t;
  typedef struct { int cyc; logic [2:0] kind; logic [SW-1:0] b; logic [SW-1:0] e; } in_exp_t;
  out_exp_t oq[$];
  in_exp_t  iq[$];
  int       wq[$];

  int m_out[NH];
  int m_exp[NH];
  int free_at = 0;
  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      m_out[h] = 1;
      m_exp[h] = 1;
    end
    free_at = 0;
  endtask

  // One clock of stimulus; the model decides acceptance and expected results.
  task automatic step(input bit req, input int rh, input bit iv, input int ih, input int is,
                      input bit sr, input int srh, input int srv);
    bit      exp_rdy;
    int      e, v;
    string   s;
    out_exp_t o;
    in_exp_t  it;
    out_req = req; out_host = HAW'(rh);
    in_valid = iv; in_host = HAW'(ih); in_seq = SW'(is);
    seq_reset = sr; seq_reset_host = HAW'(srh); seq_reset_val = SW'(srv);
    #1;
    exp_rdy = !sr && (cyc >= free_at);
    chk("out_ready", {63'd0, out_ready}, {63'd0, exp_rdy});
    if (iv) begin
      e = m_exp[ih];
      it.cyc = cyc + 1; it.b = '0; it.e = '0;
      if (is == e) it.kind = 3'b100;
      else if (is > e) begin it.kind = 3'b010; it.b = SW'(e); it.e = SW'(is - 1); end
      else it.kind = 3'b001;
      iq.push_back(it);
    end
    if (req && exp_rdy) begin
      v = m_out[rh];
      s = $sformatf("%0d", v);
      o.cyc = cyc + LAT; o.seq = SW'(v); o.asc = '0; o.len = 4'(s.len());
      for (int i = 0; i < s.len(); i++) o.asc[8*i +: 8] = s[s.len()-1-i];
      oq.push_back(o);
      if (v == MAXV) begin wq.push_back(cyc + 1); m_out[rh] = 1; end
      else m_out[rh] = v + 1;
      free_at = cyc + LAT;
    end
    if (iv && is == m_exp[ih]) m_exp[ih] = (is == MAXV) ? 1 : is + 1;
    if (sr) begin
      m_out[srh] = (srv == 0) ? 1 : srv;
      m_exp[srh] = (srv == 0) ? 1 : srv;
    end
    @(posedge clk); #1;
    out_req = 1'b0; in_valid = 1'b0; seq_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_free();
    while (cyc < free_at) idle(1);
  endtask

  task automatic drain();
    int budget = 0;
    while ((oq.size() != 0 || iq.size() != 0 || wq.size() != 0) && budget < 200) begin
      idle(1);
      budget++;
    end
    if (budget >= 200) flag("drain_timeout");
  endtask

  task automatic req(input int h);
    wait_free();
    step(1, h, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic inc(input int h, input int s);
    step(0, 0, 1, h, s, 0, 0, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (started && !rst) begin
      if (out_valid) begin
        if (oq.size() == 0) flag("unexpected_out_valid");
        else begin
          out_exp_t o;
          o = oq.pop_front();
          chk("out_cycle", 64'(cyc), 64'(o.cyc));
          chk("out_seq", 64'(out_seq), 64'(o.seq));
          chk("out_ascii", 64'(out_ascii), 64'(o.asc));
          chk("out_len", 64'(out_len), 64'(o.len));
        end
      end
      if (oq.size() != 0 && oq[0].cyc < cyc) begin
        flag("missed_out_valid");
        void'(oq.pop_front());
      end
      if (seq_wrap) begin
        if (wq.size() == 0) flag("unexpected_seq_wrap");
        else chk("wrap_cycle", 64'(cyc), 64'(wq.pop_front()));
      end
      if (wq.size() != 0 && wq[0] < cyc) begin
        flag("missed_seq_wrap");
        void'(wq.pop_front());
      end
      if (in_ok || in_gap || in_low) begin
        if (iq.size() == 0) flag("unexpected_in_result");
        else begin
          in_exp_t it;
          it = iq.pop_front();
          chk("in_cycle", 64'(cyc), 64'(it.cyc));
          chk("in_kind", {61'd0, in_ok, in_gap, in_low}, {61'd0, it.kind});
          if (it.kind == 3'b010) begin
            chk("gap_begin", 64'(gap_begin), 64'(it.b));
            chk("gap_end", 64'(gap_end), 64'(it.e));
          end
        end
      end
      if (iq.size() != 0 && iq[0].cyc < cyc) begin
        flag("missed_in_result");
        void'(iq.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, e, s, r, v;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, out_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);
    chk("rst_ascii", 64'(out_ascii), 64'd0);
    chk("rst_len", 64'(out_len), 64'd0);
    chk("rst_flags", {60'd0, seq_wrap, in_ok, in_gap, in_low}, 64'd0);
    chk("rst_gap", {24'd0, gap_begin, gap_end}, 64'd0);
    started = 1'b1;
    @(posedge clk); #1;

    // First two outgoing numbers on host 0
    req(0); req(0); drain();
    // Host 2 incoming 1, 5, 3, 1
    inc(2, 1); inc(2, 5); inc(2, 3); inc(2, 1); drain();
    // Sequence reset host 1 to 1000
    step(0, 0, 0, 0, 0, 1, 1, 1000);
    req(1); inc(1, 1000); drain();
    // Wrap on host 3, host 0 unaffected
    step(0, 0, 0, 0, 0, 1, 3, MAXV);
    req(3); req(3); req(0); drain();
    // Reset value 0 loads as 1
    step(0, 0, 0, 0, 0, 1, 2, 0);
    req(2); inc(2, 1); drain();
    // Request during conversion is dropped
    req(0); idle(4); step(1, 0, 0, 0, 0, 0, 0, 0); drain();
    // rst mid-conversion aborts and restores counters
    req(0); idle(9);
    rst = 1'b1;
    oq.delete();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(30);
    req(0); drain();
    // Simultaneous request, check and reset on host 0
    step(1, 0, 1, 0, 1, 1, 0, 50);
    req(0); inc(0, 50); drain();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bit rq, iv, sr;
      int rh, srv, srh;
      rq = ($urandom % 3) == 0;
      rh = $urandom % NH;
      iv = ($urandom % 2) == 0;
      h = $urandom % NH;
      e = m_exp[h];
      r = $urandom % 4;
      s = e;
      if (r == 1) begin
        s = e + 1 + ($urandom % 5);
        if (s > MAXV) s = e;
      end else if (r == 2) begin
        s = (e > 6) ? e - 1 - ($urandom % 5) : 1;
      end else if (r == 3) begin
        s = $urandom & MAXV;
      end
      sr = ($urandom % 20) == 0;
      srh = $urandom % NH;
      v = $urandom % 3;
      srv = (v == 0) ? 0 : (v == 1) ? MAXV - 1 : $urandom % 2000;
      step(rq, rh, iv, h, s, sr, srh, srv);
    end
    drain();

    chk("final_out_queue", 64'(oq.size()), 64'd0);
    chk("final_in_queue", 64'(iq.size()), 64'd0);
    chk("final_wrap_queue", 64'(wq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
